// File: rtl/mc_control_pkg.sv
// Shared opcodes, state encodings and control-field codes for the multicycle controller.
// Defining MC_CONTROL_TRAP_EN adds the TRAP state.
package mc_control_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [STATE_W-1:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
`ifdef MC_CONTROL_TRAP_EN
        , StTrap   = 4'd11
`endif
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RESULT_ALU = 2'b10;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic is_mem_op(logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mc_control_if.sv
// Controller-to-datapath bundle: opcode/status in, enables and selects out.
// MC_CONTROL_TRAP_EN adds i_trap_clr and o_illegal.
interface mc_control_if #(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned IMMSRC_W = 2
);
    logic [OPCODE_W-1:0] i_opcode;
    logic                i_Zero;
    logic                i_mem_ready;
    logic                o_PCWrite;
    logic                o_IRWrite;
    logic                o_RegWrite;
    logic                o_MemWrite;
    logic                o_AdrSrc;
    logic [1:0]          o_ResultSrc;
    logic [1:0]          o_ALUSrcA;
    logic [1:0]          o_ALUSrcB;
    logic [ALUOP_W-1:0]  o_ALUOp;
    logic [IMMSRC_W-1:0] o_ImmSrc;
    logic [3:0]          o_state;
`ifdef MC_CONTROL_TRAP_EN
    logic                i_trap_clr;
    logic                o_illegal;
`endif

    modport master (
        output i_opcode, i_Zero, i_mem_ready,
`ifdef MC_CONTROL_TRAP_EN
        output i_trap_clr,
        input  o_illegal,
`endif
        input  o_PCWrite, o_IRWrite, o_RegWrite, o_MemWrite, o_AdrSrc,
        input  o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_ImmSrc, o_state
    );

    modport slave (
        input  i_opcode, i_Zero, i_mem_ready,
`ifdef MC_CONTROL_TRAP_EN
        input  i_trap_clr,
        output o_illegal,
`endif
        output o_PCWrite, o_IRWrite, o_RegWrite, o_MemWrite, o_AdrSrc,
        output o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ALUOp, o_ImmSrc, o_state
    );

endinterface

// File: rtl/imm_src_dec.sv
// Combinational opcode-to-immediate-format decoder; R-type and unknown opcodes give I (00).
module imm_src_dec
    import mc_control_pkg::*;
#(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned IMMSRC_W = 2
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [IMMSRC_W-1:0] o_imm_src
);

    logic [6:0] w_op;
    assign w_op = 7'(i_opcode);

    always_comb begin
        o_imm_src = IMMSRC_W'(IMM_I);
        case (w_op)
            OP_LOAD:  o_imm_src = IMMSRC_W'(IMM_I);
            OP_ITYPE: o_imm_src = IMMSRC_W'(IMM_I);
            OP_STORE: o_imm_src = IMMSRC_W'(IMM_S);
            OP_BEQ:   o_imm_src = IMMSRC_W'(IMM_B);
            OP_JAL:   o_imm_src = IMMSRC_W'(IMM_J);
            default:  o_imm_src = IMMSRC_W'(IMM_I);
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle RISC-V main controller: Moore FSM plus the memory-ready and zero-gated enables.
// Defining MC_CONTROL_TRAP_EN routes unknown opcodes to a TRAP state cleared by i_trap_clr.
module mc_control
    import mc_control_pkg::*;
#(
    parameter int unsigned OPCODE_W = 7,
    parameter int unsigned ALUOP_W  = 2,
    parameter int unsigned IMMSRC_W = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mc_control_if.slave  io_ctl
);

    state_e r_state;
    state_e w_next;

    logic [6:0]          w_op;
    logic                w_rdy;
    logic                w_pc_write;
    logic                w_ir_write;
    logic                w_reg_write;
    logic                w_mem_write;
    logic                w_adr_src;
    logic [1:0]          w_result_src;
    logic [1:0]          w_alu_src_a;
    logic [1:0]          w_alu_src_b;
    logic [ALUOP_W-1:0]  w_alu_op;
    logic [IMMSRC_W-1:0] w_imm_src;

    assign w_op  = 7'(io_ctl.i_opcode);
    assign w_rdy = io_ctl.i_mem_ready;

    imm_src_dec #(
        .OPCODE_W (OPCODE_W),
        .IMMSRC_W (IMMSRC_W)
    ) u_imm_src_dec (
        .i_opcode  (io_ctl.i_opcode),
        .o_imm_src (w_imm_src)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StFetch;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            StFetch: begin
                if (w_rdy) w_next = StDecode;
            end
            StDecode: begin
`ifdef MC_CONTROL_TRAP_EN
                w_next = StTrap;
`else
                w_next = StFetch;
`endif
                if (is_mem_op(w_op))      w_next = StMemAdr;
                else if (w_op == OP_RTYPE) w_next = StExecR;
                else if (w_op == OP_ITYPE) w_next = StExecI;
                else if (w_op == OP_BEQ)   w_next = StBeq;
                else if (w_op == OP_JAL)   w_next = StJal;
            end
            StMemAdr: begin
                // Opcode is stable from the IR; anything else here is a corrupted IR.
                if (w_op == OP_LOAD)       w_next = StMemRead;
                else if (w_op == OP_STORE) w_next = StMemWrite;
                else                       w_next = StFetch;
            end
            StMemRead:  if (w_rdy) w_next = StMemWb;
            StMemWrite: if (w_rdy) w_next = StFetch;
            StMemWb:    w_next = StFetch;
            StExecR:    w_next = StAluWb;
            StExecI:    w_next = StAluWb;
            StAluWb:    w_next = StFetch;
            StBeq:      w_next = StFetch;
            StJal:      w_next = StAluWb;
`ifdef MC_CONTROL_TRAP_EN
            StTrap:     if (io_ctl.i_trap_clr) w_next = StFetch;
`endif
            default:    w_next = StFetch;
        endcase
    end

    always_comb begin
        w_pc_write   = 1'b0;
        w_ir_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = ALUOP_W'(ALUOP_ADD);
        case (r_state)
            StFetch: begin
                w_ir_write   = w_rdy;
                w_pc_write   = w_rdy;
                w_alu_src_b  = SRCB_FOUR;
                w_result_src = RESULT_ALU;
            end
            StMemRead:  w_adr_src = 1'b1;
            StMemWrite: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            StMemWb:    w_reg_write = 1'b1;
            StAluWb:    w_reg_write = 1'b1;
            StExecR:    w_alu_op = ALUOP_W'(ALUOP_FUNCT);
            StExecI:    w_alu_op = ALUOP_W'(ALUOP_FUNCT);
            StBeq: begin
                w_alu_op   = ALUOP_W'(ALUOP_SUB);
                w_pc_write = io_ctl.i_Zero;
            end
            StJal:      w_pc_write = 1'b1;
            default: ;
        endcase
        // FETCH's ready-gated enables must stay quiet while reset is held.
        if (i_rst) begin
            w_pc_write  = 1'b0;
            w_ir_write  = 1'b0;
            w_reg_write = 1'b0;
            w_mem_write = 1'b0;
        end
    end

    assign io_ctl.o_PCWrite   = w_pc_write;
    assign io_ctl.o_IRWrite   = w_ir_write;
    assign io_ctl.o_RegWrite  = w_reg_write;
    assign io_ctl.o_MemWrite  = w_mem_write;
    assign io_ctl.o_AdrSrc    = w_adr_src;
    assign io_ctl.o_ResultSrc = w_result_src;
    assign io_ctl.o_ALUSrcA   = w_alu_src_a;
    assign io_ctl.o_ALUSrcB   = w_alu_src_b;
    assign io_ctl.o_ALUOp     = w_alu_op;
    assign io_ctl.o_ImmSrc    = w_imm_src;
    assign io_ctl.o_state     = r_state;
`ifdef MC_CONTROL_TRAP_EN
    assign io_ctl.o_illegal   = (r_state == StTrap);
`endif

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed scenarios plus random instruction streams
// checked against an instruction-level path/output model.
module tb_mc_control;
    import mc_control_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mc_control_if bus ();

    mc_control dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_ctl (bus)
    );

    typedef struct packed {
        logic       pcw;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       adr;
        logic [1:0] res;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] imm;
        logic [3:0] st;
    } obs_t;

    typedef state_e path_t[$];

    function automatic obs_t observe();
        obs_t o;
        o.pcw   = bus.o_PCWrite;
        o.irw   = bus.o_IRWrite;
        o.rw    = bus.o_RegWrite;
        o.mw    = bus.o_MemWrite;
        o.adr   = bus.o_AdrSrc;
        o.res   = bus.o_ResultSrc;
        o.srca  = bus.o_ALUSrcA;
        o.srcb  = bus.o_ALUSrcB;
        o.aluop = bus.o_ALUOp;
        o.imm   = bus.o_ImmSrc;
        o.st    = bus.o_state;
        return o;
    endfunction

    // Instruction-level view: which phases an opcode walks through, and what each phase drives.
    function automatic path_t path_of(logic [6:0] op);
        path_t p;
        p = '{StFetch, StDecode};
        case (op)
            7'b0000011: p = '{StFetch, StDecode, StMemAdr, StMemRead, StMemWb};
            7'b0100011: p = '{StFetch, StDecode, StMemAdr, StMemWrite};
            7'b0110011: p = '{StFetch, StDecode, StExecR, StAluWb};
            7'b0010011: p = '{StFetch, StDecode, StExecI, StAluWb};
            7'b1100011: p = '{StFetch, StDecode, StBeq};
            7'b1101111: p = '{StFetch, StDecode, StJal, StAluWb};
            default: ;
        endcase
        return p;
    endfunction

    function automatic obs_t model(state_e ph, logic rdy, logic zero, logic [6:0] op);
        obs_t m;
        m    = '0;
        m.st = ph;
        m.imm = (op == 7'b0100011) ? 2'b01 :
                (op == 7'b1100011) ? 2'b10 :
                (op == 7'b1101111) ? 2'b11 : 2'b00;
        case (ph)
            StFetch:    begin m.pcw = rdy; m.irw = rdy; m.res = 2'b10; m.srcb = 2'b10; end
            StMemRead:  m.adr = 1'b1;
            StMemWrite: begin m.adr = 1'b1; m.mw = 1'b1; end
            StMemWb:    m.rw = 1'b1;
            StAluWb:    m.rw = 1'b1;
            StExecR:    m.aluop = 2'b10;
            StExecI:    m.aluop = 2'b10;
            StBeq:      begin m.aluop = 2'b01; m.pcw = zero; end
            StJal:      m.pcw = 1'b1;
            default: ;
        endcase
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst             = 1'b1;
        bus.i_opcode    = '0;
        bus.i_Zero      = 1'b0;
        bus.i_mem_ready = 1'b0;
`ifdef MC_CONTROL_TRAP_EN
        bus.i_trap_clr  = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        rst             = 1'b1;
        bus.i_opcode    = 7'b1100011;
        bus.i_Zero      = 1'b1;
        bus.i_mem_ready = 1'b1;
`ifdef MC_CONTROL_TRAP_EN
        bus.i_trap_clr  = 1'b0;
`endif
        tick();
        tick();
        o = observe();
        n_checks++;
        if (o.st !== 4'(StFetch)) begin
            n_fail++;
            $display("FAIL reset_state: got %0d want %0d", o.st, StFetch);
        end
        n_checks++;
        if ({o.pcw, o.irw, o.rw, o.mw} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_enables: got %b want 0000", {o.pcw, o.irw, o.rw, o.mw});
        end
        rst = 1'b0;
        #1;
        o = observe();
        n_checks++;
        if ({o.irw, o.pcw} !== 2'b11) begin
            n_fail++;
            $display("FAIL reset_first_fetch: irw/pcw got %b want 11", {o.irw, o.pcw});
        end
        tick();
        n_checks++;
        if (bus.o_state !== 4'(StDecode)) begin
            n_fail++;
            $display("FAIL reset_first_edge: state got %0d want %0d", bus.o_state, StDecode);
        end
        tick();
        tick();
        n_checks++;
        if (bus.o_state !== 4'(StFetch)) begin
            n_fail++;
            $display("FAIL beq_latency: state got %0d want %0d", bus.o_state, StFetch);
        end
    endtask

    task automatic test_load();
        state_e exp_q[6] = '{StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StFetch};
        apply_reset();
        bus.i_opcode    = 7'b0000011;
        bus.i_mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_checks++;
            if (bus.o_state !== 4'(exp_q[i])) begin
                n_fail++;
                $display("FAIL load_state[%0d]: got %0d want %0d", i, bus.o_state, exp_q[i]);
            end
            n_checks++;
            if (bus.o_RegWrite !== (exp_q[i] == StMemWb)) begin
                n_fail++;
                $display("FAIL load_regwrite[%0d]: got %b want %b", i, bus.o_RegWrite,
                         exp_q[i] == StMemWb);
            end
            tick();
        end
    endtask

    task automatic test_store();
        int mw_cycles = 0;
        apply_reset();
        bus.i_opcode    = 7'b0100011;
        bus.i_mem_ready = 1'b1;
        tick();
        tick();
        tick();
        for (int i = 0; i < 8; i++) begin
            bus.i_mem_ready = (i == 3);
            #1;
            if (bus.o_state !== 4'(StMemWrite)) break;
            if (bus.o_MemWrite === 1'b1 && bus.o_AdrSrc === 1'b1) mw_cycles++;
            tick();
        end
        n_checks++;
        if (mw_cycles != 4) begin
            n_fail++;
            $display("FAIL store_memwrite_cycles: got %0d want 4", mw_cycles);
        end
        n_checks++;
        if (bus.o_state !== 4'(StFetch)) begin
            n_fail++;
            $display("FAIL store_return: state got %0d want %0d", bus.o_state, StFetch);
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            apply_reset();
            bus.i_opcode    = 7'b1100011;
            bus.i_mem_ready = 1'b1;
            tick();
            tick();
            bus.i_Zero = 1'(z);
            #1;
            n_checks++;
            if (bus.o_state !== 4'(StBeq) || bus.o_PCWrite !== 1'(z)) begin
                n_fail++;
                $display("FAIL beq_pcwrite_z%0d: state %0d pcw %b want state %0d pcw %0d",
                         z, bus.o_state, bus.o_PCWrite, StBeq, z);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.i_opcode    = 7'b0110011;
        bus.i_mem_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (bus.o_state !== 4'(StExecR)) begin
            n_fail++;
            $display("FAIL midrst_reach_execr: got %0d want %0d", bus.o_state, StExecR);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.o_state !== 4'(StFetch) || bus.o_RegWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async: state %0d rw %b want state %0d rw 0",
                     bus.o_state, bus.o_RegWrite, StFetch);
        end
        tick();
        rst             = 1'b0;
        bus.i_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.o_state !== 4'(StFetch) || bus.o_RegWrite !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_writeback[%0d]: state %0d rw %b", i, bus.o_state,
                         bus.o_RegWrite);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        bus.i_opcode    = 7'b1111111;
        bus.i_mem_ready = 1'b1;
        tick();
        tick();
`ifdef MC_CONTROL_TRAP_EN
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (bus.o_state !== 4'(StTrap) || bus.o_illegal !== 1'b1 ||
                {bus.o_PCWrite, bus.o_IRWrite, bus.o_RegWrite, bus.o_MemWrite} !== 4'b0) begin
                n_fail++;
                $display("FAIL trap_hold[%0d]: state %0d illegal %b", i, bus.o_state,
                         bus.o_illegal);
            end
            tick();
        end
        bus.i_trap_clr = 1'b1;
        tick();
        bus.i_trap_clr = 1'b0;
        n_checks++;
        if (bus.o_state !== 4'(StFetch) || bus.o_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL trap_clear: state %0d illegal %b want state %0d illegal 0",
                     bus.o_state, bus.o_illegal, StFetch);
        end
`else
        n_checks++;
        if (bus.o_state !== 4'(StFetch)) begin
            n_fail++;
            $display("FAIL illegal_to_fetch: got %0d want %0d", bus.o_state, StFetch);
        end
`endif
    endtask

    task automatic test_fetch_stall();
        apply_reset();
        bus.i_opcode    = 7'b0110011;
        bus.i_mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if ({bus.o_IRWrite, bus.o_PCWrite} !== 2'b00 || bus.o_state !== 4'(StFetch)) begin
                n_fail++;
                $display("FAIL fetch_stall[%0d]: irw/pcw %b state %0d want 00 state %0d", i,
                         {bus.o_IRWrite, bus.o_PCWrite}, bus.o_state, StFetch);
            end
            tick();
        end
        bus.i_mem_ready = 1'b1;
        tick();
        n_checks++;
        if (bus.o_state !== 4'(StDecode)) begin
            n_fail++;
            $display("FAIL fetch_release: got %0d want %0d", bus.o_state, StDecode);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                               7'b1100011, 7'b1101111, 7'b0110111};
`ifdef MC_CONTROL_TRAP_EN
        int unsigned n_ops = 6;
`else
        int unsigned n_ops = 7;
`endif
        apply_reset();
        for (int n = 0; n < 40; n++) begin
            logic [6:0] op;
            path_t      p;
            op = ops[$urandom_range(n_ops - 1, 0)];
            p  = path_of(op);
            bus.i_opcode = op;
            foreach (p[k]) begin
                bit mem_ph;
                int waits;
                mem_ph = (p[k] == StFetch) || (p[k] == StMemRead) || (p[k] == StMemWrite);
                waits  = mem_ph ? int'($urandom_range(2, 0)) : 0;
                for (int w = 0; w <= waits; w++) begin
                    obs_t exp_o;
                    obs_t act_o;
                    bus.i_mem_ready = mem_ph ? (w == waits) : 1'($urandom);
                    bus.i_Zero      = 1'($urandom);
                    #1;
                    exp_o = model(p[k], bus.i_mem_ready, bus.i_Zero, op);
                    act_o = observe();
                    n_checks++;
                    if (act_o !== exp_o) begin
                        n_fail++;
                        $display("FAIL random op=%b phase=%0d: got %h want %h", op, p[k],
                                 act_o, exp_o);
                    end
                    tick();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_store();
        test_beq();
        test_reset_mid();
        test_illegal();
        test_fetch_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
